// File: rtl/interrupt_control_signals_if.sv
// Bundle between the 8259A ack/poll control FSM (master) and the INT/clear/ack slice (slave).
// ICS_ONEHOT_CHECK_EN adds the protocol_error signal.
interface interrupt_control_signals_if;
  logic       write_initial_command_word_1;
  logic [7:0] interrupt;
  logic       end_of_acknowledge_sequence;
  logic       end_of_poll_command;
  logic [1:0] next_control_state;
  logic       latch_in_service;
  logic [1:0] control_state;
  logic       interrupt_to_cpu;
  logic       freeze;
  logic [7:0] clear_interrupt_request;
  logic [7:0] acknowledge_interrupt;
  logic [7:0] interrupt_when_ack1;
`ifdef ICS_ONEHOT_CHECK_EN
  logic       protocol_error;
`endif

  modport master (
    output write_initial_command_word_1, interrupt, end_of_acknowledge_sequence,
           end_of_poll_command, next_control_state, latch_in_service, control_state,
    input  interrupt_to_cpu, freeze, clear_interrupt_request, acknowledge_interrupt,
           interrupt_when_ack1
`ifdef ICS_ONEHOT_CHECK_EN
    , input protocol_error
`endif
  );

  modport slave (
    input  write_initial_command_word_1, interrupt, end_of_acknowledge_sequence,
           end_of_poll_command, next_control_state, latch_in_service, control_state,
    output interrupt_to_cpu, freeze, clear_interrupt_request, acknowledge_interrupt,
           interrupt_when_ack1
`ifdef ICS_ONEHOT_CHECK_EN
    , output protocol_error
`endif
  );
endinterface

// File: rtl/interrupt_control_signals.sv
// 8259A control slice: INT pin, freeze strobe, IRR clear / ISR set vectors, ACK1 vector capture.
// Optional sticky one-hot check on the ISR latch path when ICS_ONEHOT_CHECK_EN is defined.
module interrupt_control_signals (
  input logic                            clock,
  input logic                            reset_n,
  interrupt_control_signals_if.slave     bus
);

  typedef enum logic [1:0] {
    CTL_READY = 2'b00,
    CTL_ACK1  = 2'b01,
    CTL_ACK2  = 2'b10,
    CTL_POLL  = 2'b11
  } ctl_state_e;

  ctl_state_e next_state;
  ctl_state_e cur_state;

  logic       int_q, int_d;
  logic       freeze_q, freeze_d;
  logic [7:0] ack1_q, ack1_d;

  assign next_state = ctl_state_e'(bus.next_control_state);
  assign cur_state  = ctl_state_e'(bus.control_state);

  always_comb begin
    int_d = int_q;
    if (bus.write_initial_command_word_1)    int_d = 1'b0;
    else if (bus.interrupt != '0)            int_d = 1'b1;
    else if (bus.end_of_acknowledge_sequence) int_d = 1'b0;
    else if (bus.end_of_poll_command)        int_d = 1'b0;

    freeze_d = (next_state != CTL_READY);

    ack1_d = ack1_q;
    if (bus.write_initial_command_word_1) ack1_d = '0;
    else if (cur_state == CTL_ACK1)       ack1_d = bus.interrupt;
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      int_q    <= 1'b0;
      freeze_q <= 1'b0;
      ack1_q   <= '0;
    end else begin
      int_q    <= int_d;
      freeze_q <= freeze_d;
      ack1_q   <= ack1_d;
    end
  end

  // Zero-latency IRR/ISR strobes; held quiet while the part is in reset.
  always_comb begin
    bus.clear_interrupt_request = '0;
    bus.acknowledge_interrupt   = '0;
    if (reset_n) begin
      if (bus.write_initial_command_word_1) begin
        bus.clear_interrupt_request = '1;
      end else if (bus.latch_in_service) begin
        bus.clear_interrupt_request = bus.interrupt;
        bus.acknowledge_interrupt   = bus.interrupt;
      end
    end
  end

  assign bus.interrupt_to_cpu    = int_q;
  assign bus.freeze              = freeze_q;
  assign bus.interrupt_when_ack1 = ack1_q;

`ifdef ICS_ONEHOT_CHECK_EN
  logic perr_q, perr_d;
  logic not_onehot;

  // Zero, or more than one bit set, both count as a violation.
  assign not_onehot = (bus.interrupt == '0) ||
                      ((bus.interrupt & (bus.interrupt - 8'd1)) != '0);

  always_comb begin
    perr_d = perr_q;
    if (bus.write_initial_command_word_1)             perr_d = 1'b0;
    else if (bus.latch_in_service && not_onehot)      perr_d = 1'b1;
  end

  always_ff @(posedge clock) begin
    if (!reset_n) perr_q <= 1'b0;
    else          perr_q <= perr_d;
  end

  assign bus.protocol_error = perr_q;
`endif

endmodule

// File: tb/tb_interrupt_control_signals.sv
// Directed scoreboard bench for interrupt_control_signals: stimulus pushes hand-computed
// expectations, a monitor pops and checks them one cycle at a time.
module tb_interrupt_control_signals;

  logic clock = 1'b0;
  logic reset_n;

  interrupt_control_signals_if bus ();

  interrupt_control_signals dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clock = ~clock;

  typedef struct {
    string      name;
    logic [7:0] clr;
    logic [7:0] ack;
    logic       intc;
    logic       frz;
    logic [7:0] iwa;
    logic       perr;
  } exp_t;

  exp_t exp_q[$];
  int unsigned total = 0;
  int unsigned bad   = 0;

  task automatic chk8(input string name, input string field, input logic [7:0] act,
                      input logic [7:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s.%s actual=%h required=%h", name, field, act, req);
    end
  endtask

  // Inputs change on the falling edge; combinational outputs stay valid through the rising
  // edge, and the registered ones are checked just after it.
  task automatic apply(input string name, input logic rst, input logic icw1,
                       input logic [7:0] intr, input logic eoa, input logic eop,
                       input logic [1:0] ncs, input logic lis, input logic [1:0] cs,
                       input logic [7:0] e_clr, input logic [7:0] e_ack, input logic e_int,
                       input logic e_frz, input logic [7:0] e_iwa, input logic e_perr);
    exp_t e;
    @(negedge clock);
    reset_n                          = rst;
    bus.write_initial_command_word_1 = icw1;
    bus.interrupt                    = intr;
    bus.end_of_acknowledge_sequence  = eoa;
    bus.end_of_poll_command          = eop;
    bus.next_control_state           = ncs;
    bus.latch_in_service             = lis;
    bus.control_state                = cs;
    e.name = name; e.clr = e_clr; e.ack = e_ack; e.intc = e_int;
    e.frz = e_frz; e.iwa = e_iwa; e.perr = e_perr;
    exp_q.push_back(e);
  endtask

  logic [7:0] clr_s, ack_s;

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clock);
      clr_s = bus.clear_interrupt_request;
      ack_s = bus.acknowledge_interrupt;
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk8(e.name, "clr",  clr_s, e.clr);
        chk8(e.name, "ack",  ack_s, e.ack);
        chk8(e.name, "int",  {7'd0, bus.interrupt_to_cpu}, {7'd0, e.intc});
        chk8(e.name, "frz",  {7'd0, bus.freeze}, {7'd0, e.frz});
        chk8(e.name, "iwa1", bus.interrupt_when_ack1, e.iwa);
`ifdef ICS_ONEHOT_CHECK_EN
        chk8(e.name, "perr", {7'd0, bus.protocol_error}, {7'd0, e.perr});
`endif
      end
    end
  end

  initial begin : stimulus
    int unsigned waited;
    reset_n = 1'b0;
    bus.write_initial_command_word_1 = 1'b0;
    bus.interrupt = '0;
    bus.end_of_acknowledge_sequence = 1'b0;
    bus.end_of_poll_command = 1'b0;
    bus.next_control_state = 2'b00;
    bus.latch_in_service = 1'b0;
    bus.control_state = 2'b00;

    //     name        rst icw1 intr  eoa eop ncs    lis cs     clr    ack    int frz iwa    perr
    apply("rst0",      0,  0,   8'h00, 0, 0, 2'b00, 0, 2'b00, 8'h00, 8'h00, 0, 0, 8'h00, 0);
    apply("rst1",      0,  0,   8'h00, 0, 0, 2'b00, 0, 2'b00, 8'h00, 8'h00, 0, 0, 8'h00, 0);
    apply("idle",      1,  0,   8'h00, 0, 0, 2'b00, 0, 2'b00, 8'h00, 8'h00, 0, 0, 8'h00, 0);
    apply("intpath",   1,  0,   8'h02, 0, 0, 2'b00, 1, 2'b00, 8'h02, 8'h02, 1, 0, 8'h00, 0);
    apply("icw1",      1,  1,   8'hFF, 0, 0, 2'b01, 0, 2'b00, 8'hFF, 8'h00, 0, 1, 8'h00, 0);
    apply("ack1cap",   1,  0,   8'h80, 0, 0, 2'b01, 0, 2'b01, 8'h00, 8'h00, 1, 1, 8'h80, 0);
    apply("endack",    1,  0,   8'h00, 1, 0, 2'b00, 0, 2'b10, 8'h00, 8'h00, 0, 0, 8'h80, 0);
    apply("pollset",   1,  0,   8'h04, 0, 0, 2'b11, 0, 2'b00, 8'h00, 8'h00, 1, 1, 8'h80, 0);
    apply("pollend",   1,  0,   8'h00, 0, 1, 2'b00, 0, 2'b11, 8'h00, 8'h00, 0, 0, 8'h80, 0);
    apply("reint",     1,  0,   8'h04, 0, 0, 2'b00, 0, 2'b00, 8'h00, 8'h00, 1, 0, 8'h80, 0);
    apply("pollhold",  1,  0,   8'h04, 0, 1, 2'b00, 0, 2'b00, 8'h00, 8'h00, 1, 0, 8'h80, 0);
    apply("pollclr",   1,  0,   8'h00, 0, 1, 2'b00, 0, 2'b00, 8'h00, 8'h00, 0, 0, 8'h80, 0);
    apply("lis08",     1,  0,   8'h08, 0, 0, 2'b00, 1, 2'b00, 8'h08, 8'h08, 1, 0, 8'h80, 0);
    apply("hold",      1,  0,   8'h00, 0, 0, 2'b00, 0, 2'b00, 8'h00, 8'h00, 1, 0, 8'h80, 0);
    apply("ack1zero",  1,  0,   8'h00, 0, 0, 2'b00, 0, 2'b01, 8'h00, 8'h00, 1, 0, 8'h00, 0);
    apply("multibit",  1,  0,   8'h06, 0, 0, 2'b00, 1, 2'b00, 8'h06, 8'h06, 1, 0, 8'h00, 1);
    apply("sticky",    1,  0,   8'h00, 0, 0, 2'b00, 0, 2'b00, 8'h00, 8'h00, 1, 0, 8'h00, 1);
    apply("icw1dom",   1,  1,   8'h06, 1, 1, 2'b00, 1, 2'b01, 8'hFF, 8'h00, 0, 0, 8'h00, 0);
    apply("liszero",   1,  0,   8'h00, 0, 0, 2'b00, 1, 2'b00, 8'h00, 8'h00, 0, 0, 8'h00, 1);
    apply("rstforce",  0,  0,   8'hFF, 0, 0, 2'b11, 1, 2'b01, 8'h00, 8'h00, 0, 0, 8'h00, 0);

    waited = 0;
    while (exp_q.size() != 0 && waited < 10) begin
      @(negedge clock);
      waited++;
    end
    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain pending=%0d required=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
